fetch_unit: RTL and testbench

//  Parametrised instruction-fetch front end for the pipelined core.
//  - Owns the PC register and issues sequential requests to a 1-cycle-latency synchronous imem.
//  - Buffers fetched {pc, instr} pairs in a FIFO_DEPTH-entry queue.
//  - Presents buffered pairs to decode over a valid/ready handshake.
//  - Supports redirect (branch/jump) with flush of the queue and of the in-flight request.

---
 rtl/fetch_unit.sv | 141 ++++++++++++++
 tb/tb_fetch_unit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end.
//  Owns the PC, issues sequential reads to a 1-cycle-latency synchronous imem,
//  queues returned {pc, instr} pairs in a FIFO_DEPTH-entry buffer and hands
//  them to decode over valid/ready. A redirect flushes the queue and squashes
//  the pending return, then restarts fetch at redirect_pc.
//
//  Optional feature macro: FETCH_ALIGN_CHECK_EN
//    defined   - a redirect with redirect_pc[1:0] != 0 sets the sticky
//                fetch_misaligned flag and stops requests until an aligned
//                redirect arrives (which clears the flag).
//    undefined - fetch_misaligned is tied 0 and redirect_pc is word-aligned
//                on load.
//
//  Ports:
//    clk, rst          clock (rising edge), async active-high reset
//    imem_req          read request this cycle
//    imem_addr         byte address of the request (current fetch PC)
//    imem_rdata        data for the previous cycle's request
//    redirect_valid    flush and restart at redirect_pc
//    redirect_pc       new fetch address
//    out_valid         queue head valid
//    out_ready         decode accepts head
//    out_instr, out_pc head instruction and its PC
//    fetch_misaligned  sticky misaligned-redirect flag
module fetch_unit #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 32,
  parameter int FIFO_DEPTH    = 4,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0]    imem_rdata,
  input  logic                     redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_instr,
  output logic [ADDRESS_WIDTH-1:0] out_pc,
  output logic                     fetch_misaligned
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [ADDRESS_WIDTH-1:0] fetch_pc;
  logic [ADDRESS_WIDTH-1:0] inflight_pc;
  logic [ADDRESS_WIDTH-1:0] load_pc;
  logic                     inflight;

  logic [ADDRESS_WIDTH-1:0] pc_mem    [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]    instr_mem [FIFO_DEPTH];
  logic [PW-1:0]            wptr;
  logic [PW-1:0]            rptr;
  logic [CW-1:0]            count;

  logic [CW:0] occupancy;
  logic        credit;
  logic        stall;
  logic        push;
  logic        pop;

`ifdef FETCH_ALIGN_CHECK_EN
  logic misaligned;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misaligned <= 1'b0;
    end else if (redirect_valid) begin
      misaligned <= |redirect_pc[1:0];
    end
  end

  assign fetch_misaligned = misaligned;
  assign stall            = misaligned;
  assign load_pc          = redirect_pc;
`else
  assign fetch_misaligned = 1'b0;
  assign stall            = 1'b0;
  assign load_pc          = redirect_pc & ~ADDRESS_WIDTH'(3);
`endif

  // Credit counts the in-flight request as an occupied slot, so every
  // return always has room and no push is ever dropped.
  always_comb begin
    occupancy = {1'b0, count} + {{CW{1'b0}}, inflight};
    credit    = occupancy < (CW+1)'(FIFO_DEPTH);
    imem_req  = !rst && !redirect_valid && !stall && credit;
    push      = inflight && !redirect_valid;
    pop       = (count != '0) && out_ready && !redirect_valid;
  end

  assign imem_addr = fetch_pc;
  assign out_valid = (count != '0);
  // Head fields are forced to zero while empty so reset shows 0 without
  // having to clear the storage array.
  assign out_pc    = out_valid ? pc_mem[rptr]    : '0;
  assign out_instr = out_valid ? instr_mem[rptr] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= load_pc;
      inflight <= 1'b0;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
    end else begin
      if (imem_req) begin
        inflight    <= 1'b1;
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + ADDRESS_WIDTH'(4);
      end else begin
        inflight <= 1'b0;
      end
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wptr]    <= inflight_pc;
      instr_mem[wptr] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [15:0] out_pc;
  logic        fetch_misaligned;

  logic        req_b;
  logic [15:0] addr_b;
  logic [31:0] rdata_b;
  logic        valid_b;
  logic [31:0] instr_b;
  logic [15:0] pc_b;
  logic        mis_b;

  int total = 0;
  int bad   = 0;

  logic [15:0] dr_pc   [5] = '{16'h0000, 16'h0004, 16'h0008, 16'h000C, 16'h0010};
  logic [15:0] dr_addr [5] = '{16'h0010, 16'h0010, 16'h0014, 16'h0018, 16'h001C};
  logic        dr_req  [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

  fetch_unit dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc),
    .fetch_misaligned(fetch_misaligned)
  );

  fetch_unit #(.RESET_PC(16'hFFF8)) dut_wrap (
    .clk(clk), .rst(rst),
    .imem_req(req_b), .imem_addr(addr_b), .imem_rdata(rdata_b),
    .redirect_valid(1'b0), .redirect_pc(16'h0000),
    .out_valid(valid_b), .out_ready(1'b1),
    .out_instr(instr_b), .out_pc(pc_b),
    .fetch_misaligned(mis_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] f(input logic [15:0] a);
    return {a ^ 16'h5A5A, a};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Acts as the imem for both instances: data for a request appears the cycle after.
  task automatic step();
    logic        pa, pb;
    logic [15:0] aa, ab;
    pa = imem_req; aa = imem_addr;
    pb = req_b;    ab = addr_b;
    @(posedge clk);
    #1;
    imem_rdata = pa ? f(aa) : 32'hDEADBEEF;
    rdata_b    = pb ? f(ab) : 32'hDEADBEEF;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_req",   imem_req, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_pc",    out_pc, 0);
    chk("rst_instr", out_instr, 0);
    chk("rst_mis",   fetch_misaligned, 0);
    chk("rst_req_b", req_b, 0);
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [15:0] w;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
    imem_rdata = '0; rdata_b = '0;
    #1;
    do_reset();

    // streaming with out_ready=1, plus wrap instance
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("s_req",   imem_req, 1);
      chk("s_addr",  imem_addr, 32'(4*k));
      chk("s_valid", out_valid, k >= 2);
      if (k >= 2) begin
        chk("s_pc",    out_pc, 32'(4*(k-2)));
        chk("s_instr", out_instr, f(16'(4*(k-2))));
        w = 16'hFFF8 + 16'(4*(k-2));
        chk("w_pc",    pc_b, w);
        chk("w_instr", instr_b, f(w));
      end
      step();
    end

    // backpressure: exactly FIFO_DEPTH requests, head held
    out_ready = 1'b0;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      #1;
      chk("bp_req", imem_req, c < 4);
      if (c < 4) chk("bp_addr", imem_addr, 32'(4*c));
      chk("bp_valid", out_valid, c >= 2);
      if (c >= 2) begin
        chk("bp_pc",    out_pc, 0);
        chk("bp_instr", out_instr, f(16'h0000));
      end
      step();
    end

    // reset with the queue full
    #1;
    chk("full_valid", out_valid, 1);
    do_reset();
    #1;
    chk("rs_req",  imem_req, 1);
    chk("rs_addr", imem_addr, 0);
    for (int c = 0; c < 5; c++) step();

    // drain while refill resumes
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("dr_pc",   out_pc, dr_pc[i]);
      chk("dr_req",  imem_req, dr_req[i]);
      chk("dr_addr", imem_addr, dr_addr[i]);
      step();
    end

    // redirect with 3 queued and one return pending
    out_ready = 1'b0;
    do_reset();
    for (int c = 0; c < 4; c++) step();
    redirect_valid = 1'b1; redirect_pc = 16'h0100;
    #1;
    chk("rd_pre_valid", out_valid, 1);
    chk("rd_pre_req",   imem_req, 0);
    step();
    redirect_valid = 1'b0;
    #1;
    chk("rd_valid0", out_valid, 0);
    chk("rd_addr0",  imem_addr, 16'h0100);
    chk("rd_req0",   imem_req, 1);
    step();
    #1;
    chk("rd_valid1", out_valid, 0);
    chk("rd_addr1",  imem_addr, 16'h0104);
    step();
    #1;
    chk("rd_valid2", out_valid, 1);
    chk("rd_pc2",    out_pc, 16'h0100);
    chk("rd_instr2", out_instr, f(16'h0100));
    step();

    // back-to-back redirects: last wins
    redirect_valid = 1'b1; redirect_pc = 16'h0300;
    step();
    redirect_pc = 16'h0400;
    step();
    redirect_valid = 1'b0;
    #1;
    chk("bb_addr",  imem_addr, 16'h0400);
    chk("bb_valid", out_valid, 0);
    chk("bb_req",   imem_req, 1);
    step();
    step();
    #1;
    chk("bb_valid2", out_valid, 1);
    chk("bb_pc2",    out_pc, 16'h0400);
    chk("bb_instr2", out_instr, f(16'h0400));
    step();

    // misaligned redirect
    redirect_valid = 1'b1; redirect_pc = 16'h0102;
    step();
    redirect_valid = 1'b0;
    #1;
`ifdef FETCH_ALIGN_CHECK_EN
    chk("ma_flag",  fetch_misaligned, 1);
    chk("ma_req",   imem_req, 0);
    chk("ma_valid", out_valid, 0);
    step();
    #1;
    chk("ma_req2",  imem_req, 0);
    chk("ma_flag2", fetch_misaligned, 1);
    step();
    redirect_valid = 1'b1; redirect_pc = 16'h0200;
    step();
    redirect_valid = 1'b0;
    #1;
    chk("al_flag", fetch_misaligned, 0);
    chk("al_req",  imem_req, 1);
    chk("al_addr", imem_addr, 16'h0200);
`else
    chk("ma_flag",  fetch_misaligned, 0);
    chk("ma_req",   imem_req, 1);
    chk("ma_addr",  imem_addr, 16'h0100);
    chk("ma_valid", out_valid, 0);
`endif
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
